// File: rtl/site_mutation_scheduler.sv
// Per-site nucleotide substitution for one branch: one random draw per site, child sampled from the P row of the parent base.
// Two cycles per site (FETCH, SAMPLE) plus one DONE cycle; an rnd_valid stall holds the FETCH state.
module site_mutation_scheduler #(
  parameter int NUM_SITES = 16,
  parameter int SITE_W    = 4,
  parameter int PROB_W    = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2*NUM_SITES-1:0] parent_seq,
  input  logic [16*PROB_W-1:0]   matrix_P,
  input  logic [PROB_W-1:0]      rnd,
  input  logic                   rnd_valid,
  output logic                   rnd_ready,
  output logic                   busy,
  output logic [SITE_W-1:0]      site_idx,
  output logic [2*NUM_SITES-1:0] child_seq,
  output logic                   done
);

  localparam int SEQ_W = 2 * NUM_SITES;
  localparam int MAT_W = 16 * PROB_W;
  localparam int CUM_W = PROB_W + 2;
  localparam logic [SITE_W-1:0] LAST_SITE = SITE_W'(NUM_SITES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SAMPLE, DONE} state_t;

  state_t             state_q, state_d;
  logic [SEQ_W-1:0]   parent_q, parent_d;
  logic [MAT_W-1:0]   mat_q, mat_d;
  logic [PROB_W-1:0]  rnd_q, rnd_d;
  logic [SITE_W-1:0]  site_q, site_d;
  logic [SEQ_W-1:0]   child_q, child_d;

  logic [SITE_W:0]    bit_base;
  logic [1:0]         parent_nuc;
  logic [PROB_W-1:0]  p0, p1, p2;
  logic [CUM_W-1:0]   c0, c1, c2, rnd_ext;
  logic [1:0]         child_nuc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      parent_q <= '0;
      mat_q    <= '0;
      rnd_q    <= '0;
      site_q   <= '0;
      child_q  <= '0;
    end else begin
      state_q  <= state_d;
      parent_q <= parent_d;
      mat_q    <= mat_d;
      rnd_q    <= rnd_d;
      site_q   <= site_d;
      child_q  <= child_d;
    end
  end

  // Row of the latched matrix selected by the parent base at the current site.
  always_comb begin
    bit_base   = {site_q, 1'b0};
    parent_nuc = parent_q[bit_base +: 2];
    p0 = '0;
    p1 = '0;
    p2 = '0;
    for (int r = 0; r < 4; r++) begin
      if (parent_nuc == 2'(r)) begin
        p0 = mat_q[(4*r+0)*PROB_W +: PROB_W];
        p1 = mat_q[(4*r+1)*PROB_W +: PROB_W];
        p2 = mat_q[(4*r+2)*PROB_W +: PROB_W];
      end
    end
    c0      = {2'b00, p0};
    c1      = c0 + {2'b00, p1};
    c2      = c1 + {2'b00, p2};
    rnd_ext = {2'b00, rnd_q};
    if (rnd_ext < c0)      child_nuc = 2'd0;
    else if (rnd_ext < c1) child_nuc = 2'd1;
    else if (rnd_ext < c2) child_nuc = 2'd2;
    else                   child_nuc = 2'd3;
  end

  always_comb begin
    state_d  = state_q;
    parent_d = parent_q;
    mat_d    = mat_q;
    rnd_d    = rnd_q;
    site_d   = site_q;
    child_d  = child_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          parent_d = parent_seq;
          mat_d    = matrix_P;
          site_d   = '0;
          child_d  = '0;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        if (rnd_valid) begin
          rnd_d   = rnd;
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        child_d[bit_base +: 2] = child_nuc;
        if (site_q == LAST_SITE) begin
          state_d = DONE;
        end else begin
          site_d  = site_q + SITE_W'(1);
          state_d = FETCH;
        end
      end
      DONE: begin
        site_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rnd_ready = (state_q == FETCH);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign site_idx  = site_q;
  assign child_seq = child_q;

endmodule
